// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter
// Shares the single write port of the video memory between the CPU WVM path
// and a rectangle-fill engine. A CPU write always wins and goes straight to
// the port in the same cycle. The fill engine writes one cell of a clipped
// rectangle on every cycle the CPU leaves free, walking it in row-major order.
//
// Ports
//   Clock, Reset    system clock; synchronous active-high reset
//   iCpuWrite       CPU write request, single cycle, never stalled
//   iCpuAddress     CPU cell address {row, col}
//   iCpuData        CPU colour
//   iFillStart      start strobe, only honoured in IDLE
//   iFillX0/Y0      top-left column / row
//   iFillW/H        width / height minus one
//   iFillColor      fill colour
//   iFillAbort      abort a running fill
//   oWriteEnable    video RAM write enable
//   oWriteAddress   video RAM write address {row, col}
//   oWriteData      video RAM write data
//   oBusy           high while a fill is in progress
//   oDone           one-cycle pulse after a fill completes or is aborted
module vram_write_arbiter #(
    parameter int DATA_WIDTH = 3,
    parameter int COORD_BITS = 5
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iCpuWrite,
    input  logic [2*COORD_BITS-1:0] iCpuAddress,
    input  logic [DATA_WIDTH-1:0]   iCpuData,
    input  logic                    iFillStart,
    input  logic [COORD_BITS-1:0]   iFillX0,
    input  logic [COORD_BITS-1:0]   iFillY0,
    input  logic [COORD_BITS-1:0]   iFillW,
    input  logic [COORD_BITS-1:0]   iFillH,
    input  logic [DATA_WIDTH-1:0]   iFillColor,
    input  logic                    iFillAbort,
    output logic                    oWriteEnable,
    output logic [2*COORD_BITS-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0]   oWriteData,
    output logic                    oBusy,
    output logic                    oDone
);

    localparam logic [COORD_BITS-1:0] MAX_COORD = '1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                  state, stateNext;
    logic [COORD_BITS-1:0]   x0, xe, ye, cx, cy;
    logic [DATA_WIDTH-1:0]   color;
    logic                    engineWrite;
    logic                    lastCell;

    // Edges are computed one bit wider so an overflow past the last
    // column/row saturates instead of wrapping back to 0.
    logic [COORD_BITS:0]     xSum, ySum;
    logic [COORD_BITS-1:0]   xeClip, yeClip;

    assign xSum   = {1'b0, iFillX0} + {1'b0, iFillW};
    assign ySum   = {1'b0, iFillY0} + {1'b0, iFillH};
    assign xeClip = xSum[COORD_BITS] ? MAX_COORD : xSum[COORD_BITS-1:0];
    assign yeClip = ySum[COORD_BITS] ? MAX_COORD : ySum[COORD_BITS-1:0];

    assign lastCell = (cx == xe) && (cy == ye);
    assign oBusy    = (state == FILL);
    assign oDone    = (state == DONE);

    always_comb begin
        stateNext     = state;
        engineWrite   = 1'b0;
        oWriteEnable  = 1'b0;
        oWriteAddress = '0;
        oWriteData    = '0;

        case (state)
            IDLE: if (iFillStart) stateNext = FILL;
            FILL: begin
                // Abort beats the engine's own write for that cycle.
                if (iFillAbort) begin
                    stateNext = DONE;
                end else if (!iCpuWrite) begin
                    engineWrite = 1'b1;
                    if (lastCell) stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // Reset blanks the port even against a CPU write in the same cycle.
        if (Reset) begin
            engineWrite = 1'b0;
        end else if (iCpuWrite) begin
            oWriteEnable  = 1'b1;
            oWriteAddress = iCpuAddress;
            oWriteData    = iCpuData;
        end else if (engineWrite) begin
            oWriteEnable  = 1'b1;
            oWriteAddress = {cy, cx};
            oWriteData    = color;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            x0    <= '0;
            xe    <= '0;
            ye    <= '0;
            cx    <= '0;
            cy    <= '0;
            color <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && iFillStart) begin
                x0    <= iFillX0;
                xe    <= xeClip;
                ye    <= yeClip;
                cx    <= iFillX0;
                cy    <= iFillY0;
                color <= iFillColor;
            end else if (engineWrite && !lastCell) begin
                // Row-major walk; cursor only moves on cycles it wrote.
                if (cx != xe) begin
                    cx <= cx + 1'b1;
                end else begin
                    cx <= x0;
                    cy <= cy + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter. The driver pushes every expected
// port write and done pulse, tagged with the cycle it must appear in, into a
// queue; a monitor on the falling edge pops and compares each one the DUT
// presents. Extra events or leftovers count as mismatches.
module tb_vram_write_arbiter;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iCpuWrite;
    logic [9:0] iCpuAddress;
    logic [2:0] iCpuData;
    logic       iFillStart;
    logic [4:0] iFillX0, iFillY0, iFillW, iFillH;
    logic [2:0] iFillColor;
    logic       iFillAbort;
    logic       oWriteEnable;
    logic [9:0] oWriteAddress;
    logic [2:0] oWriteData;
    logic       oBusy;
    logic       oDone;

    vram_write_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .iCpuWrite(iCpuWrite), .iCpuAddress(iCpuAddress), .iCpuData(iCpuData),
        .iFillStart(iFillStart), .iFillX0(iFillX0), .iFillY0(iFillY0),
        .iFillW(iFillW), .iFillH(iFillH), .iFillColor(iFillColor),
        .iFillAbort(iFillAbort),
        .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
        .oWriteData(oWriteData), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc++;

    typedef struct {
        bit         isDone;
        int         cyc;
        logic [9:0] addr;
        logic [2:0] data;
    } ev_t;

    ev_t expQ[$];
    int  nCmp = 0;
    int  nErr = 0;

    function automatic void expW(int c, logic [9:0] a, logic [2:0] d);
        ev_t e;
        e.isDone = 1'b0; e.cyc = c; e.addr = a; e.data = d;
        expQ.push_back(e);
    endfunction

    function automatic void expD(int c);
        ev_t e;
        e.isDone = 1'b1; e.cyc = c; e.addr = '0; e.data = '0;
        expQ.push_back(e);
    endfunction

    task automatic chk(string name, int act, int req);
        nCmp++;
        if (act != req) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic checkEv(bit isDone);
        ev_t e;
        nCmp++;
        if (expQ.size() == 0) begin
            nErr++;
            $display("FAIL unexpected %s: cycle %0d addr %h data %0d, expected nothing",
                     isDone ? "done" : "write", cyc, oWriteAddress, oWriteData);
        end else begin
            e = expQ.pop_front();
            if (e.isDone != isDone || e.cyc != cyc ||
                (!isDone && (e.addr != oWriteAddress || e.data != oWriteData))) begin
                nErr++;
                $display("FAIL event: got %s cyc %0d addr %h data %0d, expected %s cyc %0d addr %h data %0d",
                         isDone ? "done" : "write", cyc, oWriteAddress, oWriteData,
                         e.isDone ? "done" : "write", e.cyc, e.addr, e.data);
            end
        end
    endtask

    always @(negedge Clock) begin
        if (oWriteEnable) checkEv(1'b0);
        if (oDone)        checkEv(1'b1);
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic startFill(int x0, int y0, int w, int h, int col);
        iFillX0 = 5'(x0); iFillY0 = 5'(y0); iFillW = 5'(w); iFillH = 5'(h);
        iFillColor = 3'(col);
        iFillStart = 1'b1;
    endtask

    int k;

    initial begin
        Reset = 1'b1; iCpuWrite = 1'b0; iCpuAddress = '0; iCpuData = '0;
        iFillStart = 1'b0; iFillX0 = '0; iFillY0 = '0; iFillW = '0; iFillH = '0;
        iFillColor = '0; iFillAbort = 1'b0;
        step(2);

        // Reset blocks a concurrent CPU write and holds outputs at 0.
        iCpuWrite = 1'b1; iCpuAddress = 10'h3AA; iCpuData = 3'd7;
        @(negedge Clock);
        chk("reset_we",   oWriteEnable,  0);
        chk("reset_addr", oWriteAddress, 0);
        chk("reset_data", oWriteData,    0);
        chk("reset_busy", oBusy,         0);
        chk("reset_done", oDone,         0);
        step();
        iCpuWrite = 1'b0; Reset = 1'b0;
        step(2);

        // Single cell.
        k = cyc;
        startFill(3, 4, 0, 0, 5);
        expW(k + 1, 10'h083, 3'd5); expD(k + 2);
        step(); iFillStart = 1'b0;
        @(negedge Clock); chk("single_busy", oBusy, 1);
        step(4);

        // 2x2 rectangle.
        k = cyc;
        startFill(1, 1, 1, 1, 2);
        expW(k + 1, 10'h021, 3'd2); expW(k + 2, 10'h022, 3'd2);
        expW(k + 3, 10'h041, 3'd2); expW(k + 4, 10'h042, 3'd2); expD(k + 5);
        step(); iFillStart = 1'b0;
        step(7);

        // Clip at the bottom-right corner, no wrap.
        k = cyc;
        startFill(30, 31, 5, 5, 4);
        expW(k + 1, 10'h3FE, 3'd4); expW(k + 2, 10'h3FF, 3'd4); expD(k + 3);
        step(); iFillStart = 1'b0;
        step(5);

        // CPU contention on the 2nd FILL cycle of a 2x2 fill.
        k = cyc;
        startFill(1, 1, 1, 1, 2);
        expW(k + 1, 10'h021, 3'd2); expW(k + 2, 10'h155, 3'd7);
        expW(k + 3, 10'h022, 3'd2); expW(k + 4, 10'h041, 3'd2);
        expW(k + 5, 10'h042, 3'd2); expD(k + 6);
        step(); iFillStart = 1'b0;
        step();
        iCpuWrite = 1'b1; iCpuAddress = 10'h155; iCpuData = 3'd7;
        step(); iCpuWrite = 1'b0;
        @(negedge Clock); chk("contend_busy", oBusy, 1);
        step(6);

        // Full-screen fill, second start ignored, abort on 3rd FILL cycle.
        k = cyc;
        startFill(0, 0, 31, 31, 6);
        expW(k + 1, 10'h000, 3'd6); expW(k + 2, 10'h001, 3'd6); expD(k + 4);
        step(); iFillStart = 1'b0;
        step();
        startFill(5, 5, 0, 0, 1);
        step(); iFillStart = 1'b0;
        iFillAbort = 1'b1;
        step(); iFillAbort = 1'b0;
        step();
        @(negedge Clock); chk("abort_idle_busy", oBusy, 0);
        step(3);

        // Start and CPU write in the same IDLE cycle.
        k = cyc;
        startFill(0, 0, 0, 0, 1);
        iCpuWrite = 1'b1; iCpuAddress = 10'h2AB; iCpuData = 3'd3;
        expW(k, 10'h2AB, 3'd3); expW(k + 1, 10'h000, 3'd1); expD(k + 2);
        step(); iFillStart = 1'b0; iCpuWrite = 1'b0;
        step(4);

        // Reset mid-fill: no done pulse, following CPU write passes.
        k = cyc;
        startFill(0, 0, 31, 31, 3);
        expW(k + 1, 10'h000, 3'd3);
        step(); iFillStart = 1'b0;
        step();
        Reset = 1'b1;
        step(); Reset = 1'b0;
        @(negedge Clock);
        chk("rstfill_busy", oBusy,        0);
        chk("rstfill_we",   oWriteEnable, 0);
        chk("rstfill_done", oDone,        0);
        step();
        iCpuWrite = 1'b1; iCpuAddress = 10'h1F0; iCpuData = 3'd4;
        expW(k + 4, 10'h1F0, 3'd4);
        step(); iCpuWrite = 1'b0;
        step(4);

        chk("leftover_events", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run did not end, expected finish");
        $fatal(1);
    end

endmodule
